parity_rr_scheduler: RTL and testbench

Shares one bit-serial even-parity engine among NUM_REQ requesters using round-robin arbitration.
- Each requester presents a DATA_W-bit word.
- The scheduler grants one requester, latches its word and shifts it through the engine one bit per cycle.
- It returns the even-parity bit (XOR of all data bits) with the winner's ID.
- Sits between multiple producers and a single parity resource.

---
 rtl/parity_pkg.sv | 18 +
 rtl/parity_serial_engine.sv | 36 +++
 rtl/parity_rr_scheduler.sv | 87 ++++++++
 tb/tb_parity_rr_scheduler.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// parity_pkg: shared FSM encoding, defaults and width helpers for parity_rr_scheduler.
package parity_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
  localparam int DEFAULT_DATA_W = 8;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction
  function automatic int id_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction
endpackage

// File: rtl/parity_serial_engine.sv
// parity_serial_engine: bit-serial even-parity accumulator with a DATA_W-cycle bit counter.
module parity_serial_engine
  import parity_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  localparam int CNT_W = id_w(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift_en,
  output logic              last_bit,
  output logic              acc
);
  logic [DATA_W-1:0] r_shreg;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_acc;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_acc   <= 1'b0;
    end else if (load) begin
      r_shreg <= load_data;
      r_cnt   <= '0;
      r_acc   <= 1'b0;
    end else if (shift_en) begin
      r_acc   <= r_acc ^ r_shreg[0];
      r_shreg <= r_shreg >> 1;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end
  assign last_bit = r_cnt == CNT_W'(DATA_W - 1);
  assign acc      = r_acc;
endmodule

// File: rtl/parity_rr_scheduler.sv
// parity_rr_scheduler: round-robin share of one serial parity engine among NUM_REQ requesters.
// Optional PARITY_CHECK_EN adds req_par input and par_err output.
module parity_rr_scheduler
  import parity_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEFAULT_DATA_W,
  localparam int ID_W   = id_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
`ifdef PARITY_CHECK_EN
  input  logic [NUM_REQ-1:0]        req_par,
  output logic                      par_err,
`endif
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      done,
  output logic [ID_W-1:0]           done_id,
  output logic                      parity
);
  state_t              r_state, w_next;
  logic [ID_W-1:0]     r_ptr, w_win, r_done_id;
  logic [NUM_REQ-1:0]  r_grant;
  logic                r_parity, w_load, w_last, w_acc;
  always_comb begin
    w_win = r_ptr;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req[(int'(r_ptr) + k) % NUM_REQ]) w_win = ID_W'((int'(r_ptr) + k) % NUM_REQ);
  end
  always_comb begin
    w_load = (r_state == ST_IDLE) && (|req);
    w_next = w_load ? ST_SHIFT :
             (r_state == ST_SHIFT) ? (w_last ? ST_DONE : ST_SHIFT) : ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr     <= ID_W'(NUM_REQ - 1);
      r_grant   <= '0;
      r_done_id <= '0;
      r_parity  <= 1'b0;
    end else begin
      if (w_load) begin
        r_ptr   <= w_win;
        r_grant <= NUM_REQ'(1) << w_win;
      end else if (r_state == ST_DONE) begin
        r_grant <= '0;
      end
      if (r_state == ST_SHIFT && w_last) r_done_id <= r_ptr;
      if (r_state == ST_DONE) r_parity <= w_acc;
    end
  end
  parity_serial_engine #(.DATA_W(DATA_W)) u_engine (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_data(req_data[w_win*DATA_W +: DATA_W]),
    .shift_en (r_state == ST_SHIFT),
    .last_bit (w_last),
    .acc      (w_acc)
  );
  // In DONE the accumulator is final and stable; r_parity keeps it once the engine reloads.
  assign parity  = (r_state == ST_DONE) ? w_acc : r_parity;
  assign grant   = r_grant;
  assign busy    = r_state != ST_IDLE;
  assign done    = r_state == ST_DONE;
  assign done_id = r_done_id;
`ifdef PARITY_CHECK_EN
  logic r_exp, r_par_err;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_exp     <= 1'b0;
      r_par_err <= 1'b0;
    end else begin
      if (w_load) r_exp <= req_par[w_win];
      if (r_state == ST_DONE) r_par_err <= w_acc ^ r_exp;
    end
  end
  assign par_err = (r_state == ST_DONE) ? (w_acc ^ r_exp) : r_par_err;
`endif
endmodule

// File: tb/tb_parity_rr_scheduler.sv
// tb_parity_rr_scheduler: directed and randomized checks against a round-robin/parity reference model.
module tb_parity_rr_scheduler;
  localparam int N = 4;
  localparam int W = 8;
  localparam int IDW = 2;
  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] req;
  logic [N*W-1:0] req_data;
  logic [N-1:0] grant;
  logic busy, done, parity;
  logic [IDW-1:0] done_id;
`ifdef PARITY_CHECK_EN
  logic [N-1:0] req_par;
  logic par_err;
`endif
  int checks = 0;
  int errors = 0;
  int m_ptr;

  parity_rr_scheduler #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
`ifdef PARITY_CHECK_EN
    .req_par(req_par), .par_err(par_err),
`endif
    .grant(grant), .busy(busy), .done(done), .done_id(done_id), .parity(parity)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] rand_req();
    return N'($urandom_range(1, (1 << N) - 1));
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    req_data = '0;
`ifdef PARITY_CHECK_EN
    req_par = '0;
`endif
    step(2);
    reset = 1'b0;
    m_ptr = N - 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({grant, busy, done, done_id, parity} !== '0) begin
      errors++;
      $display("FAIL reset: grant=%b busy=%b done=%b done_id=%0d parity=%b, want all 0", grant, busy, done, done_id, parity);
    end
`ifdef PARITY_CHECK_EN
    checks++;
    if (par_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_par_err: got %b want 0", par_err);
    end
`endif
    step(3);
    checks++;
    if (busy !== 1'b0 || grant !== '0) begin
      errors++;
      $display("FAIL idle_no_req: busy=%b grant=%b want 0", busy, grant);
    end
  endtask

  task automatic test_single();
    logic [W-1:0] words [4] = '{8'ha8, 8'hff, 8'h00, 8'h01};
    do_reset();
    foreach (words[i]) begin
      req = 4'b0001;
      req_data = '0;
      req_data[W-1:0] = words[i];
      step();
      checks++;
      if (grant !== 4'b0001 || busy !== 1'b1) begin
        errors++;
        $display("FAIL single_grant w=%h: grant=%b busy=%b want 0001/1", words[i], grant, busy);
      end
      for (int k = 1; k < W; k++) begin
        step();
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL single_early_done w=%h k=%0d: done=%b want 0", words[i], k, done);
        end
      end
      step();
      checks++;
      if (done !== 1'b1 || done_id !== 2'd0 || parity !== ^words[i]) begin
        errors++;
        $display("FAIL single_done w=%h: done=%b id=%0d par=%b want 1/0/%b", words[i], done, done_id, parity, ^words[i]);
      end
      req = '0;
      step();
      checks++;
      if (grant !== '0 || busy !== 1'b0 || done !== 1'b0 || parity !== ^words[i] || done_id !== 2'd0) begin
        errors++;
        $display("FAIL single_after w=%h: grant=%b busy=%b done=%b par=%b id=%0d want 0/0/0/%b/0", words[i], grant, busy, done, parity, done_id, ^words[i]);
      end
    end
  endtask

  task automatic test_fair();
    int exp;
    logic [W-1:0] w;
    do_reset();
    req = 4'b1111;
    req_data = {8'h80, 8'h3c, 8'h07, 8'h0f};
    exp = pick(req, m_ptr);
    step();
    for (int s = 0; s < 5; s++) begin
      w = req_data[exp*W +: W];
      checks++;
      if (grant !== N'(1 << exp)) begin
        errors++;
        $display("FAIL fair_grant s=%0d: grant=%b want %b", s, grant, N'(1 << exp));
      end
      step(W);
      checks++;
      if (done !== 1'b1 || done_id !== IDW'(exp) || parity !== ^w) begin
        errors++;
        $display("FAIL fair_done s=%0d: done=%b id=%0d par=%b want 1/%0d/%b", s, done, done_id, parity, exp, ^w);
      end
      m_ptr = exp;
      exp = pick(req, m_ptr);
      step(2);
    end
    req = '0;
    step(W + 2);
  endtask

  task automatic test_random();
    int exp;
    logic [W-1:0] w;
    do_reset();
    req = rand_req();
    req_data = {$urandom(), $urandom()};
    exp = pick(req, m_ptr);
    w = req_data[exp*W +: W];
    step();
    for (int s = 0; s < 40; s++) begin
      checks++;
      if (grant !== N'(1 << exp) || busy !== 1'b1) begin
        errors++;
        $display("FAIL rand_grant s=%0d: grant=%b busy=%b want %b/1", s, grant, busy, N'(1 << exp));
      end
      step(2);
      req = rand_req();
      req_data = {$urandom(), $urandom()};
      step(W - 2);
      checks++;
      if (done !== 1'b1 || done_id !== IDW'(exp) || parity !== ^w || grant !== N'(1 << exp)) begin
        errors++;
        $display("FAIL rand_done s=%0d: done=%b id=%0d par=%b grant=%b want 1/%0d/%b/%b", s, done, done_id, parity, grant, exp, ^w, N'(1 << exp));
      end
      m_ptr = exp;
      req = rand_req();
      req_data = {$urandom(), $urandom()};
      exp = pick(req, m_ptr);
      w = req_data[exp*W +: W];
      step(2);
    end
    req = '0;
    step(W + 2);
  endtask

  task automatic test_drop();
    do_reset();
    req = 4'b0001;
    req_data = '0;
    req_data[W-1:0] = 8'ha8;
    step();
    step(2);
    req = '0;
    req_data = '0;
    step(W - 2);
    checks++;
    if (done !== 1'b1 || done_id !== 2'd0 || parity !== 1'b1) begin
      errors++;
      $display("FAIL drop_done: done=%b id=%0d par=%b want 1/0/1", done, done_id, parity);
    end
    step(3);
    checks++;
    if (busy !== 1'b0 || grant !== '0) begin
      errors++;
      $display("FAIL drop_idle: busy=%b grant=%b want 0", busy, grant);
    end
  endtask

  task automatic test_abort();
    do_reset();
    req = 4'b0001;
    req_data = '0;
    req_data[W-1:0] = 8'ha8;
    step();
    step(3);
    reset = 1'b1;
    step();
    checks++;
    if (grant !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_now: grant=%b busy=%b done=%b want 0", grant, busy, done);
    end
    reset = 1'b0;
    req = '0;
    for (int k = 0; k < W + 2; k++) begin
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_done k=%0d: done=%b busy=%b want 0", k, done, busy);
      end
    end
    req = 4'b1111;
    step();
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL abort_ptr: grant=%b want 0001", grant);
    end
    step(W);
    req = 4'b1000;
    req_data[4*W-1 -: W] = 8'h01;
    step(2);
    checks++;
    if (grant !== 4'b1000) begin
      errors++;
      $display("FAIL abort_req3: grant=%b want 1000", grant);
    end
    step(W);
    checks++;
    if (done !== 1'b1 || done_id !== 2'd3 || parity !== 1'b1) begin
      errors++;
      $display("FAIL abort_req3_done: done=%b id=%0d par=%b want 1/3/1", done, done_id, parity);
    end
    req = '0;
    step(2);
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity_check();
    do_reset();
    for (int pv = 0; pv < 2; pv++) begin
      req = 4'b0001;
      req_data = '0;
      req_data[W-1:0] = 8'ha8;
      req_par = N'(pv);
      step();
      req_par = N'(pv ^ 1);
      step(W);
      checks++;
      if (done !== 1'b1 || par_err !== (1'b1 ^ pv[0])) begin
        errors++;
        $display("FAIL par_err pv=%0d: done=%b par_err=%b want 1/%b", pv, done, par_err, 1'b1 ^ pv[0]);
      end
      req = '0;
      step();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fair();
    test_random();
    test_drop();
    test_abort();
`ifdef PARITY_CHECK_EN
    test_parity_check();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
